// File: rtl/regfile_sb.sv
// Parametrised integer register file with hardwired zero register, write-to-read bypass,
// optional registered read stage and a per-register busy scoreboard for the hazard unit.
module regfile_sb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1,
   parameter int READ_REG   = 0
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  read,
   input  logic [ADDR_WIDTH-1:0] src1_add,
   input  logic [ADDR_WIDTH-1:0] src2_add,
   output logic [DATA_WIDTH-1:0] src1_data,
   output logic [DATA_WIDTH-1:0] src2_data,
   output logic                  src1_busy,
   output logic                  src2_busy,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] dest_add,
   input  logic [DATA_WIDTH-1:0] dest_data,
   input  logic                  alloc,
   input  logic [ADDR_WIDTH-1:0] alloc_add,
   input  logic                  flush
);

   localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic                  ZERO_EN   = (ZERO_REG != 0);
   localparam logic                  BYP_EN    = (BYPASS != 0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] regs_r [DEPTH];
   logic [DEPTH-1:0]      busy_r;
   logic [DEPTH-1:0]      busy_next_s;
   logic                  wr_en_s;
   logic [DATA_WIDTH-1:0] raw1_data_s;
   logic [DATA_WIDTH-1:0] raw2_data_s;
   logic                  raw1_busy_s;
   logic                  raw2_busy_s;
   logic [DATA_WIDTH-1:0] q1_data_r;
   logic [DATA_WIDTH-1:0] q2_data_r;
   logic                  q1_busy_r;
   logic                  q2_busy_r;

   // Writes to the hardwired zero register are dropped.
   always_comb begin
      wr_en_s = write & ~(ZERO_EN & (dest_add == ADDR_ZERO));
   end

   // Register storage.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= DATA_ZERO;
         end
      end else if (wr_en_s) begin
         regs_r[dest_add] <= dest_data;
      end
   end

   // Scoreboard next state: flush, then writeback clear, then alloc set (alloc wins).
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         busy_next_s[i] = (busy_r[i] & ~flush & ~(write & (dest_add == ADDR_WIDTH'(i))))
                        | (alloc & (alloc_add == ADDR_WIDTH'(i)));
      end
      busy_next_s[0] = busy_next_s[0] & ~ZERO_EN;
   end

   // Scoreboard register.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         busy_r <= {DEPTH{1'b0}};
      end else begin
         busy_r <= busy_next_s;
      end
   end

   // Raw read port 1: zero register first, then same-cycle writeback forwarding.
   always_comb begin
      if (ZERO_EN && (src1_add == ADDR_ZERO)) begin
         raw1_data_s = DATA_ZERO;
         raw1_busy_s = 1'b0;
      end else if (BYP_EN && write && (dest_add == src1_add)) begin
         raw1_data_s = dest_data;
         raw1_busy_s = 1'b0;
      end else begin
         raw1_data_s = regs_r[src1_add];
         raw1_busy_s = busy_r[src1_add];
      end
   end

   // Raw read port 2, same priority as port 1.
   always_comb begin
      if (ZERO_EN && (src2_add == ADDR_ZERO)) begin
         raw2_data_s = DATA_ZERO;
         raw2_busy_s = 1'b0;
      end else if (BYP_EN && write && (dest_add == src2_add)) begin
         raw2_data_s = dest_data;
         raw2_busy_s = 1'b0;
      end else begin
         raw2_data_s = regs_r[src2_add];
         raw2_busy_s = busy_r[src2_add];
      end
   end

   // Registered read stage; only drives the outputs when READ_REG is set.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         q1_data_r <= DATA_ZERO;
         q2_data_r <= DATA_ZERO;
         q1_busy_r <= 1'b0;
         q2_busy_r <= 1'b0;
      end else if (read) begin
         q1_data_r <= raw1_data_s;
         q2_data_r <= raw2_data_s;
         q1_busy_r <= raw1_busy_s;
         q2_busy_r <= raw2_busy_s;
      end
   end

   assign src1_data = (READ_REG != 0) ? q1_data_r : raw1_data_s;
   assign src2_data = (READ_REG != 0) ? q2_data_r : raw2_data_s;
   assign src1_busy = (READ_REG != 0) ? q1_busy_r : raw1_busy_s;
   assign src2_busy = (READ_REG != 0) ? q2_busy_r : raw2_busy_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: default, no-bypass and registered-read instances
// share one stimulus stream; registered-read results go through an expectation queue.
module tb_regfile_sb;

   logic        Clk;
   logic        Rst;
   logic        read;
   logic        write;
   logic        alloc;
   logic        flush;
   logic [4:0]  src1_add;
   logic [4:0]  src2_add;
   logic [4:0]  dest_add;
   logic [4:0]  alloc_add;
   logic [31:0] dest_data;

   logic [31:0] d1_data, d2_data, n1_data, n2_data, r1_data, r2_data;
   logic        d1_busy, d2_busy, n1_busy, n2_busy, r1_busy, r2_busy;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_data_q[$];
   logic        exp_busy_q[$];
   logic [31:0] e_d;
   logic        e_b;

   regfile_sb dut (
      .Clk(Clk), .Rst(Rst), .read(read),
      .src1_add(src1_add), .src2_add(src2_add),
      .src1_data(d1_data), .src2_data(d2_data),
      .src1_busy(d1_busy), .src2_busy(d2_busy),
      .write(write), .dest_add(dest_add), .dest_data(dest_data),
      .alloc(alloc), .alloc_add(alloc_add), .flush(flush)
   );

   regfile_sb #(.BYPASS(0)) dut_nb (
      .Clk(Clk), .Rst(Rst), .read(read),
      .src1_add(src1_add), .src2_add(src2_add),
      .src1_data(n1_data), .src2_data(n2_data),
      .src1_busy(n1_busy), .src2_busy(n2_busy),
      .write(write), .dest_add(dest_add), .dest_data(dest_data),
      .alloc(alloc), .alloc_add(alloc_add), .flush(flush)
   );

   regfile_sb #(.READ_REG(1)) dut_rr (
      .Clk(Clk), .Rst(Rst), .read(read),
      .src1_add(src1_add), .src2_add(src2_add),
      .src1_data(r1_data), .src2_data(r2_data),
      .src1_busy(r1_busy), .src2_busy(r2_busy),
      .write(write), .dest_add(dest_add), .dest_data(dest_data),
      .alloc(alloc), .alloc_add(alloc_add), .flush(flush)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic test_reset();
      tick(); tick(); settle();
      tests++;
      if (d1_data !== 32'h0 || d1_busy !== 1'b0) begin
         fails++; $display("FAIL reset_state: got %h/%b want 00000000/0", d1_data, d1_busy);
      end
      tests++;
      if (r1_data !== 32'h0 || r1_busy !== 1'b0) begin
         fails++; $display("FAIL reset_state_rr: got %h/%b want 00000000/0", r1_data, r1_busy);
      end
      tick();
      Rst = 1'b1; write = 1'b1; dest_add = 5'd5; dest_data = 32'hDEADBEEF;
      alloc = 1'b1; alloc_add = 5'd5; src1_add = 5'd5;
      tick();
      write = 1'b0; alloc = 1'b0; read = 1'b1;
      exp_data_q.push_back(32'hDEADBEEF); exp_busy_q.push_back(1'b1);
      settle();
      tests++;
      if (d1_data !== 32'hDEADBEEF || d1_busy !== 1'b1) begin
         fails++; $display("FAIL pre_reset_write: got %h/%b want deadbeef/1", d1_data, d1_busy);
      end
      tick();
      read = 1'b0; Rst = 1'b0;
      settle();
      e_d = exp_data_q.pop_front(); e_b = exp_busy_q.pop_front();
      tests++;
      if (r1_data !== e_d || r1_busy !== e_b) begin
         fails++; $display("FAIL pre_reset_rr: got %h/%b want %h/%b", r1_data, r1_busy, e_d, e_b);
      end
      tick(); tick();
      Rst = 1'b1;
      settle();
      tests++;
      if (d1_data !== 32'h0 || d1_busy !== 1'b0) begin
         fails++; $display("FAIL reset_clears_reg: got %h/%b want 00000000/0", d1_data, d1_busy);
      end
      tests++;
      if (r1_data !== 32'h0 || r1_busy !== 1'b0) begin
         fails++; $display("FAIL reset_clears_rr: got %h/%b want 00000000/0", r1_data, r1_busy);
      end
   endtask

   task automatic test_zero_reg();
      tick();
      write = 1'b1; dest_add = 5'd0; dest_data = 32'h12345678;
      alloc = 1'b1; alloc_add = 5'd0; src1_add = 5'd0; read = 1'b1;
      exp_data_q.push_back(32'h0); exp_busy_q.push_back(1'b0);
      tick();
      write = 1'b0; alloc = 1'b0; read = 1'b0;
      settle();
      tests++;
      if (d1_data !== 32'h0 || d1_busy !== 1'b0) begin
         fails++; $display("FAIL zero_reg: got %h/%b want 00000000/0", d1_data, d1_busy);
      end
      tests++;
      if (n1_data !== 32'h0 || n1_busy !== 1'b0) begin
         fails++; $display("FAIL zero_reg_nb: got %h/%b want 00000000/0", n1_data, n1_busy);
      end
      e_d = exp_data_q.pop_front(); e_b = exp_busy_q.pop_front();
      tests++;
      if (r1_data !== e_d || r1_busy !== e_b) begin
         fails++; $display("FAIL zero_reg_rr: got %h/%b want %h/%b", r1_data, r1_busy, e_d, e_b);
      end
   endtask

   task automatic test_bypass();
      tick();
      write = 1'b1; dest_add = 5'd7; dest_data = 32'h11;
      tick();
      dest_data = 32'h22; src2_add = 5'd7;
      settle();
      tests++;
      if (d2_data !== 32'h22 || d2_busy !== 1'b0) begin
         fails++; $display("FAIL bypass_data: got %h/%b want 00000022/0", d2_data, d2_busy);
      end
      tests++;
      if (n2_data !== 32'h11 || n2_busy !== 1'b0) begin
         fails++; $display("FAIL no_bypass_data: got %h/%b want 00000011/0", n2_data, n2_busy);
      end
      tick();
      write = 1'b0;
      settle();
      tests++;
      if (d2_data !== 32'h22 || n2_data !== 32'h22) begin
         fails++; $display("FAIL bypass_committed: got %h,%h want 00000022", d2_data, n2_data);
      end
   endtask

   task automatic test_scoreboard();
      tick();
      alloc = 1'b1; alloc_add = 5'd3; src1_add = 5'd3;
      settle();
      tests++;
      if (d1_busy !== 1'b0) begin
         fails++; $display("FAIL alloc_no_forward: got %b want 0", d1_busy);
      end
      tick();
      alloc = 1'b0;
      settle();
      tests++;
      if (d1_busy !== 1'b1 || n1_busy !== 1'b1) begin
         fails++; $display("FAIL alloc_busy: got %b,%b want 1,1", d1_busy, n1_busy);
      end
      tick();
      write = 1'b1; dest_add = 5'd3; dest_data = 32'hA5;
      settle();
      tests++;
      if (d1_busy !== 1'b0 || d1_data !== 32'hA5) begin
         fails++; $display("FAIL wb_bypass: got %h/%b want 000000a5/0", d1_data, d1_busy);
      end
      tests++;
      if (n1_busy !== 1'b1 || n1_data !== 32'h0) begin
         fails++; $display("FAIL wb_no_bypass: got %h/%b want 00000000/1", n1_data, n1_busy);
      end
      tick();
      write = 1'b0;
      settle();
      tests++;
      if (n1_busy !== 1'b0 || n1_data !== 32'hA5) begin
         fails++; $display("FAIL wb_clear: got %h/%b want 000000a5/0", n1_data, n1_busy);
      end
   endtask

   task automatic test_collision();
      tick();
      alloc = 1'b1; alloc_add = 5'd9;
      tick();
      alloc_add = 5'd4;
      tick();
      alloc = 1'b0; src1_add = 5'd9; src2_add = 5'd4;
      settle();
      tests++;
      if (d1_busy !== 1'b1 || d2_busy !== 1'b1) begin
         fails++; $display("FAIL pre_collision: got %b,%b want 1,1", d1_busy, d2_busy);
      end
      tick();
      write = 1'b1; dest_add = 5'd9; dest_data = 32'h99;
      alloc = 1'b1; alloc_add = 5'd9; flush = 1'b1;
      tick();
      write = 1'b0; alloc = 1'b0; flush = 1'b0;
      settle();
      tests++;
      if (d1_busy !== 1'b1 || n1_busy !== 1'b1) begin
         fails++; $display("FAIL collision_alloc_wins: got %b,%b want 1,1", d1_busy, n1_busy);
      end
      tests++;
      if (d2_busy !== 1'b0) begin
         fails++; $display("FAIL flush_clears_other: got %b want 0", d2_busy);
      end
      tests++;
      if (d1_data !== 32'h99) begin
         fails++; $display("FAIL collision_data: got %h want 00000099", d1_data);
      end
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      settle();
      tests++;
      if (d1_busy !== 1'b0 || d1_data !== 32'h99) begin
         fails++; $display("FAIL flush_keeps_data: got %h/%b want 00000099/0", d1_data, d1_busy);
      end
   endtask

   task automatic test_registered_read();
      tick();
      write = 1'b1; dest_add = 5'd12; dest_data = 32'h55;
      tick();
      write = 1'b0; read = 1'b1; src1_add = 5'd12;
      exp_data_q.push_back(32'h55); exp_busy_q.push_back(1'b0);
      settle();
      tests++;
      if (r1_data !== 32'h0) begin
         fails++; $display("FAIL rr_not_yet: got %h want 00000000", r1_data);
      end
      tick();
      read = 1'b0; write = 1'b1; dest_add = 5'd12; dest_data = 32'h66;
      settle();
      e_d = exp_data_q.pop_front(); e_b = exp_busy_q.pop_front();
      tests++;
      if (r1_data !== e_d || r1_busy !== e_b) begin
         fails++; $display("FAIL rr_latency: got %h/%b want %h/%b", r1_data, r1_busy, e_d, e_b);
      end
      tick();
      write = 1'b0;
      settle();
      tests++;
      if (r1_data !== 32'h55 || d1_data !== 32'h66) begin
         fails++; $display("FAIL rr_hold: got rr=%h comb=%h want 00000055,00000066", r1_data, d1_data);
      end
      tick();
      read = 1'b1;
      exp_data_q.push_back(32'h66); exp_busy_q.push_back(1'b0);
      tick();
      read = 1'b0;
      settle();
      e_d = exp_data_q.pop_front(); e_b = exp_busy_q.pop_front();
      tests++;
      if (r1_data !== e_d || r1_busy !== e_b) begin
         fails++; $display("FAIL rr_reread: got %h/%b want %h/%b", r1_data, r1_busy, e_d, e_b);
      end
      tick();
      read = 1'b1; write = 1'b1; dest_add = 5'd12; dest_data = 32'h77;
      exp_data_q.push_back(32'h77); exp_busy_q.push_back(1'b0);
      tick();
      read = 1'b0; write = 1'b0;
      settle();
      e_d = exp_data_q.pop_front(); e_b = exp_busy_q.pop_front();
      tests++;
      if (r1_data !== e_d || r1_busy !== e_b) begin
         fails++; $display("FAIL rr_bypass: got %h/%b want %h/%b", r1_data, r1_busy, e_d, e_b);
      end
   endtask

   initial begin
      Rst = 1'b0; read = 1'b0; write = 1'b0; alloc = 1'b0; flush = 1'b0;
      src1_add = 5'd5; src2_add = 5'd0; dest_add = 5'd0; alloc_add = 5'd0;
      dest_data = 32'h0;
      test_reset();
      test_zero_reg();
      test_bypass();
      test_scoreboard();
      test_collision();
      test_registered_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's integer register file.
- Adds configurable width and depth, a hardwired zero register, write-to-read bypass and an optional registered read stage.
- Adds a per-register busy scoreboard: decode allocates destinations, writeback clears them, and a pipeline flush clears all pending allocations.
- Sits between decode (reads and allocation) and writeback (write) in the 5-stage RV32I pipeline; the busy outputs feed the hazard/stall unit.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.
- READ_REG, 0, when 0 reads are combinational; when 1 reads are registered with 1-cycle latency.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-low reset (sampled on the rising edge of Clk).
- read  in  1  read enable; only effective when READ_REG=1.
- src1_add  in  ADDR_WIDTH  read port 1 address.
- src2_add  in  ADDR_WIDTH  read port 2 address.
- src1_data  out  DATA_WIDTH  read port 1 data.
- src2_data  out  DATA_WIDTH  read port 2 data.
- src1_busy  out  1  port 1 register has an outstanding producer.
- src2_busy  out  1  port 2 register has an outstanding producer.
- write  in  1  writeback enable.
- dest_add  in  ADDR_WIDTH  writeback address.
- dest_data  in  DATA_WIDTH  writeback data.
- alloc  in  1  decode marks alloc_add busy.
- alloc_add  in  ADDR_WIDTH  register being allocated.
- flush  in  1  clear all busy bits.

Behaviour:
- Reset (Rst=0 at a rising edge of Clk):
  - all registers cleared to 0 and all busy bits cleared to 0;
  - registered read outputs (READ_REG=1) become 0;
  - reset overrides write, alloc and flush in the same cycle.
  - A reset asserted mid-sequence discards all pending allocations.
- Write: when write=1, dest_data is stored into dest_add at the rising edge.
  - With ZERO_REG=1 and dest_add=0 the write is dropped.
- Raw read value: reg[addr], with two overrides, in this order:
  - 0 if ZERO_REG=1 and addr=0;
  - else dest_data if BYPASS=1, write=1 and dest_add=addr.
- Raw busy value: busy[addr] AND NOT (BYPASS=1 AND write=1 AND dest_add=addr).
  - Always 0 for address 0 when ZERO_REG=1.
- READ_REG=0:
  - srcN_data and srcN_busy are the raw values, combinational, 0-cycle latency;
  - read is ignored.
- READ_REG=1:
  - on a rising edge with read=1, the raw values are captured into the output registers and are visible the following cycle;
  - with read=0 the outputs hold their previous values.
- Scoreboard update at each rising edge, in priority order:
  1. flush=1 clears every busy bit.
  2. write=1 clears busy[dest_add].
  3. alloc=1 sets busy[alloc_add]; with ZERO_REG=1 and alloc_add=0 the allocation is ignored.
  - Net effect: alloc wins over both write and flush to the same address in the same cycle, so the new producer stays pending.
- Allocation timing: an alloc is not visible on srcN_busy until the next cycle; there is no same-cycle forwarding of alloc.
- Same address on both read ports: both ports return identical data and busy.
- Register file data is never modified by flush or alloc.
- Address widths are exact: no out-of-range addresses exist and there is no wrap handling.

Test Plan:
- Reset then read:
  - hold Rst=0 for 2 edges after writing 0xDEADBEEF to reg 5;
  - release, read src1_add=5 → src1_data=0, src1_busy=0.
- Zero register:
  - write 0x12345678 to reg 0 and alloc reg 0;
  - next cycle read src1_add=0 → src1_data=0, src1_busy=0.
- Bypass, BYPASS=1, READ_REG=0:
  - reg 7 holds 0x11; same cycle write=1, dest_add=7, dest_data=0x22 and src2_add=7 → src2_data=0x22, src2_busy=0;
  - with BYPASS=0 the same stimulus → src2_data=0x11.
- Scoreboard lifecycle:
  - alloc reg 3 → next cycle src1_busy=1;
  - write reg 3 with 0xA5 → src1_busy=0 (combinationally if BYPASS=1, otherwise the following cycle), src1_data=0xA5.
- Alloc/write/flush collision:
  - reg 9 busy; same edge write=1/dest_add=9, alloc=1/alloc_add=9, flush=1 → next cycle src1_busy=1 for 9;
  - all other previously busy registers (e.g. 4) → busy=0.
- Registered read, READ_REG=1:
  - reg 12=0x55; read=1, src1_add=12 → src1_data=0x55 one cycle later;
  - then read=0, write reg 12=0x66 → src1_data holds 0x55 until the next read=1.
